// File: rtl/an_code_pkg.sv
// Shared AN-code constants and types for the encoder, decoder and their benches.
package an_code_pkg;

  localparam int A       = 61;
  localparam int K       = 24;
  localparam int A_WIDTH = 6;
  localparam int N       = K + A_WIDTH;
  localparam int CNT_W   = 16;

  // Largest legal codeword, A*(2**K-1); it must fit in N bits.
  localparam longint unsigned MAX_CODE = longint'(A) * ((longint'(1) << K) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: X = A*D by shift-add over the bits of A, one bit
// per cycle, with an optional error mask XORed onto the delivered codeword.
module an_encoder_seq #(
  parameter int A       = an_code_pkg::A,
  parameter int K       = an_code_pkg::K,
  parameter int A_WIDTH = an_code_pkg::A_WIDTH,
  parameter int N       = an_code_pkg::N,
  parameter int CNT_W   = an_code_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_data,
  input  logic [N-1:0]     in_err_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_code,
  output logic [CNT_W-1:0] code_cnt
);

  import an_code_pkg::*;

  localparam int                  IDX_W    = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(A_WIDTH - 1);
  localparam logic [A_WIDTH-1:0]  A_BITS   = A_WIDTH'(A);

  if ((A % 2) == 0) begin : g_a_even
    $fatal(1, "an_encoder_seq: A must be odd");
  end
  if (A >= (1 << A_WIDTH)) begin : g_a_wide
    $fatal(1, "an_encoder_seq: A must be below 2**A_WIDTH");
  end
  if (N != K + A_WIDTH) begin : g_n_bad
    $fatal(1, "an_encoder_seq: N must equal K + A_WIDTH");
  end

  state_e           state_q, state_d;
  logic [K-1:0]     data_q,  data_d;
  logic [N-1:0]     mask_q,  mask_d;
  logic [N-1:0]     acc_q,   acc_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [N-1:0]     code_q,  code_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             accept;
  logic             transfer;
  logic             last_step;
  logic [N-1:0]     partial;
  logic [N-1:0]     acc_sum;

  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;
  assign last_step = (state_q == BUSY) && (idx_q == LAST_IDX);

  // One shift-add step; A*(2**K-1) < 2**N so the N-bit sum never overflows.
  assign partial = A_BITS[idx_q] ? (N'(data_q) << idx_q) : '0;
  assign acc_sum = acc_q + partial;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE: begin
        if (transfer) state_d = accept ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    code_d = code_q;
    cnt_d  = cnt_q;

    if (transfer) cnt_d = cnt_q + 1'b1;

    if (accept) begin
      data_d = in_data;
      mask_d = in_err_mask;
      acc_d  = '0;
      idx_d  = '0;
    end else if (state_q == BUSY) begin
      acc_d = acc_sum;
      idx_d = idx_q + 1'b1;
      if (last_step) code_d = acc_sum ^ mask_q;
    end
  end

  // Accepting in DONE is only allowed when the current codeword leaves on the same edge.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    out_code  = code_q;
    code_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_an_encoder_seq.sv
// Directed bench for an_encoder_seq: vector table plus multi-cycle sequences.
module tb_an_encoder_seq;

  import an_code_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     in_data;
  logic [N-1:0]     in_err_mask;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_code;
  logic [CNT_W-1:0] code_cnt;

  an_encoder_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_err_mask (in_err_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .code_cnt    (code_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [K-1:0] data;
    logic [N-1:0] mask;
    logic [N-1:0] code;
  } vec_t;

  int               tests;
  int               fails;
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Offer one word and hold it exactly over the accept edge, then scramble inputs.
  task automatic accept_word(input string name, input logic [K-1:0] d, input logic [N-1:0] m);
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = d;
    in_err_mask = m;
    #1 check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_data     = K'($urandom);
    in_err_mask = N'($urandom);
  endtask

  // Count edges until out_valid, also counting BUSY cycles where in_ready was high.
  task automatic wait_done(output int lat, output int ready_bad);
    lat       = 0;
    ready_bad = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) ready_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_word(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 1'b1;
    check({name, "_cnt"}, 64'(code_cnt), 64'(exp_cnt));
    check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({name, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    int   bad;
    int   stall_bad;
    logic [N-1:0] held;

    tests = 0;
    fails = 0;
    exp_cnt = '0;

    vecs[0] = '{"single_1292", 24'd1292,     30'h0,        30'd78812};
    vecs[1] = '{"zero",        24'd0,        30'h0,        30'd0};
    vecs[2] = '{"max_data",    24'd16777215, 30'h0,        30'd1023410115};
    vecs[3] = '{"err_bit4",    24'd214,      30'h10,       30'd13038};
    vecs[4] = '{"err_msb",     24'd1,        30'h20000000, 30'd536870973};
    vecs[5] = '{"err_all",     24'd0,        30'h3fffffff, 30'd1073741823};

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_err_mask = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_code",  64'(out_code),  64'd0);
    check("rst_code_cnt",  64'(code_cnt),  64'd0);

    for (int i = 0; i < 6; i++) begin
      accept_word(vecs[i].name, vecs[i].data, vecs[i].mask);
      wait_done(lat, bad);
      check({vecs[i].name, "_latency"},    64'(lat), 64'd6);
      check({vecs[i].name, "_busy_ready"}, 64'(bad), 64'd0);
      check({vecs[i].name, "_code"},       64'(out_code), 64'(vecs[i].code));
      take_word(vecs[i].name);
    end

    // Back-to-back: in_valid held high, out_ready high, words 1,2,3.
    @(negedge clk);
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_data     = 24'd1;
    in_err_mask = '0;
    @(posedge clk);
    #1;
    for (int w = 1; w <= 3; w++) begin
      bad = 0;
      repeat (5) begin
        @(posedge clk);
        #1;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d_busy", w),  64'(bad), 64'd0);
      check($sformatf("b2b%0d_valid", w), 64'(out_valid), 64'd1);
      check($sformatf("b2b%0d_code", w),  64'(out_code), 64'(61 * w));
      check($sformatf("b2b%0d_ready", w), 64'(in_ready), 64'd1);
      if (w < 3) in_data = K'(w + 1);
      else       in_valid = 1'b0;
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 1'b1;
      check($sformatf("b2b%0d_cnt", w), 64'(code_cnt), 64'(exp_cnt));
    end
    check("b2b_end_idle",  64'(in_ready),  64'd1);
    check("b2b_end_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Backpressure: 20 stalled cycles in DONE, then a single transfer.
    accept_word("stall", 24'd5, '0);
    wait_done(lat, bad);
    check("stall_code", 64'(out_code), 64'd305);
    held      = out_code;
    stall_bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_code !== held || in_ready !== 1'b0 ||
          code_cnt !== exp_cnt) stall_bad++;
    end
    check("stall_hold", 64'(stall_bad), 64'd0);
    take_word("stall");

    // Async reset on the 3rd BUSY cycle.
    accept_word("rst_mid", 24'd7, '0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_code",  64'(out_code),  64'd0);
    check("arst_code_cnt",  64'(code_cnt),  64'd0);
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    check("arst_rel_ready", 64'(in_ready), 64'd1);
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("arst_no_stale", 64'(bad), 64'd0);
    accept_word("post_rst", 24'd3, '0);
    wait_done(lat, bad);
    check("post_rst_latency", 64'(lat), 64'd6);
    check("post_rst_code", 64'(out_code), 64'd183);
    take_word("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
